handshake_fifo_v1r1: RTL and testbench
======================================

Name: handshake_fifo_v1r1

Overview:
- Parametrised successor to the two-entry registered valid/ready stage: a DEPTH-entry elastic buffer.
- Both sides stay fully registered: o_ready, o_valid and o_value are flops, with no combinational path from input to output.
- Adds occupancy count, almost-full flag and synchronous flush.
- Sits between pipeline stages where more than one cycle of slack or rate decoupling is needed.

Parameters:
VALUE_BITS, 8, payload width in bits.
DEPTH, 4, total capacity in entries, including the output register; legal range 2..256, any integer (not restricted to power of two).
AF_LEVEL, DEPTH-1, occupancy at or above which o_almost_full asserts; legal range 1..DEPTH.

Ports:
clock  input  1  single clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
i_value  input  VALUE_BITS  upstream payload.
i_valid  input  1  upstream valid.
o_ready  output  1  registered ready to upstream.
o_value  output  VALUE_BITS  registered payload to downstream.
o_valid  output  1  registered valid to downstream.
i_ready  input  1  downstream ready.
i_flush  input  1  synchronous flush, discards all held data.
o_count  output  $clog2(DEPTH+1)  registered occupancy, 0..DEPTH.
o_almost_full  output  1  registered, equals (o_count >= AF_LEVEL).

Behaviour:
- Clock and reset: one clock (clock); reset_n is asynchronous, active-low.
- Reset values: o_ready=0, o_valid=0, o_value=0, o_count=0, o_almost_full=0, pointers=0.
- After reset: o_ready rises at the first clock edge after reset_n deasserts.
- Transfer definitions:
  - Input transfer: i_valid & o_ready.
  - Output transfer: o_valid & i_ready.
  - The payload must be held stable while o_valid=1 and i_ready=0.
- Storage:
  - Output register plus a (DEPTH-1)-entry circular array with write/read pointers.
  - Pointers wrap from DEPTH-2 to 0; no power-of-two assumption.
- Output register load (first-word-fall-through), when the output register is empty or emptied by an output transfer this cycle:
  - array non-empty: load from the array head;
  - else if input transfer: load i_value directly (bypass);
  - else: o_valid <= 0.
- Latency: an item accepted into an empty buffer appears on o_valid/o_value at the next edge (1 cycle). Throughput is 1 item/cycle sustained.
- Ordering: strict FIFO; the bypass path is used only when the array is empty.
- Count:
  - count_next = count + in_xfer - out_xfer.
  - Simultaneous in and out transfers leave the count unchanged.
  - o_count <= count_next.
- Ready: o_ready <= (count_next < DEPTH).
  - This guarantees no overflow, because occupancy grows by at most 1 per cycle.
  - Consequence: with DEPTH full and i_ready=1, o_ready returns 1 one cycle after the freeing output transfer.
- Almost-full: o_almost_full <= (count_next >= AF_LEVEL).
- Flush (i_flush=1 at an edge):
  - Pointers, o_count and o_valid clear; o_almost_full <= 0; o_ready <= 1; o_value holds.
  - An input transfer in the flush cycle is discarded.
  - An output transfer in the flush cycle completes normally; downstream keeps that item.
  - Flush has priority over all other updates.
- Boundary cases:
  - Full with no i_ready: o_ready=0; inputs are ignored even if i_valid=1.
  - Empty with i_ready=1: o_valid=0; nothing happens.
  - Full with simultaneous in and out: impossible, since o_ready=0 while full.
  - Reset mid-operation: asynchronously returns to reset values; all contents are lost.
- Illegal parameters (DEPTH<2, AF_LEVEL outside 1..DEPTH) must fail at elaboration via an assertion.

Decomposition:
- Package handshake_pkg:
  - count-width helper function (clog2(DEPTH+1));
  - pointer-width helper;
  - parameter legality check constants.
- Sub-module handshake_fifo_mem:
  - (DEPTH-1)-entry register array with write enable, write pointer and read pointer;
  - asynchronous read; no reset on the data array.
- Top level keeps the pointers, count, output register and all handshake flops.

Test Plan (VALUE_BITS=8, DEPTH=4, AF_LEVEL=3 unless noted):
- Reset release, i_valid=0: o_ready=0 while reset_n=0 and until the first edge after reset_n deasserts, then 1; o_count=0 and o_valid=0 throughout.
- Single item 0x5A into empty buffer, i_ready=1: o_valid=1 with o_value=0x5A one edge later; one cycle after that o_valid=0 and o_count=0.
- Stall fill, i_ready=0, push 0x01..0x06 back-to-back:
  - 0x01..0x04 accepted; o_count climbs to 4; o_almost_full=1 from count 3; o_ready=0 after the 4th accept.
  - After i_ready=1: outputs 0x01,0x02,0x03,0x04 in order, then 0x05,0x06 accepted once o_ready returns; no loss or duplication.
- Streaming, i_valid=1 and i_ready=1 continuously with incrementing data 0x00..0xFF: one output per cycle after 1-cycle latency; o_count steady at 1; o_ready never drops.
- Flush with 3 items held (0x10,0x11,0x12), i_ready=1, i_valid=1 carrying 0x13 on the flush edge:
  - 0x10 is delivered on that edge;
  - next cycle o_valid=0, o_count=0, o_ready=1;
  - 0x11, 0x12 and 0x13 never appear.
- Wrap-around, DEPTH=5: 200 random valid/ready cycles checked against a scoreboard model; no ordering error; o_count always equals the model occupancy.

Source files
------------

// File: rtl/handshake_fifo_v1r1_pkg.sv
`timescale 1ns/1ps
// Sizing helpers and parameter legality limits shared by the handshake FIFO files.
package handshake_pkg;

    localparam int DEPTH_MIN = 2;
    localparam int DEPTH_MAX = 256;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int count_bits(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Pointer addresses the (depth-1)-entry array behind the output register.
    function automatic int ptr_bits(input int depth);
        return (depth <= 3) ? 1 : $clog2(depth - 1);
    endfunction

    function automatic bit params_ok(input int depth, input int af_level);
        return (depth >= DEPTH_MIN) && (depth <= DEPTH_MAX) &&
               (af_level >= 1) && (af_level <= depth);
    endfunction

endpackage

// File: rtl/handshake_fifo_v1r1_if.sv
`timescale 1ns/1ps
// Upstream/downstream handshake, flush and status bundle for handshake_fifo_v1r1.
interface handshake_fifo_v1r1_if #(
    parameter int VALUE_BITS = 8,
    parameter int DEPTH      = 4
);
    localparam int CW = handshake_pkg::count_bits(DEPTH);

    logic [VALUE_BITS-1:0] i_value;
    logic                  i_valid;
    logic                  o_ready;
    logic [VALUE_BITS-1:0] o_value;
    logic                  o_valid;
    logic                  i_ready;
    logic                  i_flush;
    logic [CW-1:0]         o_count;
    logic                  o_almost_full;

    modport master (
        output i_value, i_valid, i_ready, i_flush,
        input  o_ready, o_value, o_valid, o_count, o_almost_full
    );

    modport slave (
        input  i_value, i_valid, i_ready, i_flush,
        output o_ready, o_value, o_valid, o_count, o_almost_full
    );

endinterface

// File: rtl/handshake_fifo_v1r1_mem.sv
`timescale 1ns/1ps
// Purpose: payload storage behind the output register, no reset on data.
// Latency: write visible one edge later; read is combinational from rd_ptr.
// Backpressure: none here; the caller never writes a full array.
module handshake_fifo_mem #(
    parameter int VALUE_BITS = 8,
    parameter int ENTRIES    = 3,
    parameter int PW         = 2
) (
    input  logic                  clock,
    input  logic                  wr_en,
    input  logic [PW-1:0]         wr_ptr,
    input  logic [VALUE_BITS-1:0] wr_value,
    input  logic [PW-1:0]         rd_ptr,
    output logic [VALUE_BITS-1:0] rd_value
);

    logic [VALUE_BITS-1:0] mem_q [ENTRIES];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_ptr] <= wr_value;
        end
    end

    assign rd_value = mem_q[rd_ptr];

endmodule

// File: rtl/handshake_fifo_v1r1.sv
`timescale 1ns/1ps
// Purpose: DEPTH-entry fully registered valid/ready elastic buffer with count, almost-full, flush.
// Latency: 1 cycle from accepted input to o_valid; 1 item/cycle sustained.
// Backpressure: o_ready is registered and drops once the next occupancy reaches DEPTH.
module handshake_fifo_v1r1
    import handshake_pkg::*;
#(
    parameter int VALUE_BITS = 8,
    parameter int DEPTH      = 4,
    parameter int AF_LEVEL   = DEPTH - 1
) (
    input logic                 clock,
    input logic                 reset_n,
    handshake_fifo_v1r1_if.slave bus
);

    localparam int CW      = count_bits(DEPTH);
    localparam int PW      = ptr_bits(DEPTH);
    localparam int ENTRIES = DEPTH - 1;

    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AF   = CW'(AF_LEVEL);

    if (!params_ok(DEPTH, AF_LEVEL)) begin : g_param_check
        $fatal(1, "handshake_fifo_v1r1: DEPTH must be 2..256 and AF_LEVEL 1..DEPTH");
    end

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic                  valid_q, ready_q, af_q;
    logic [VALUE_BITS-1:0] value_q;
    logic [VALUE_BITS-1:0] rd_value;

    logic          in_xfer, out_xfer, out_free, arr_empty;
    logic          load_arr, load_byp, arr_wr;
    logic [CW-1:0] count_next;

    always_comb begin
        in_xfer    = bus.i_valid & ready_q;
        out_xfer   = valid_q & bus.i_ready;
        out_free   = ~valid_q | bus.i_ready;
        // Occupancy minus the output register is what sits in the array.
        arr_empty  = (count_q == CW'(valid_q));
        load_arr   = out_free & ~arr_empty;
        load_byp   = out_free & arr_empty & in_xfer;
        arr_wr     = in_xfer & ~load_byp;
        count_next = count_q + CW'(in_xfer) - CW'(out_xfer);
    end

    handshake_fifo_mem #(
        .VALUE_BITS (VALUE_BITS),
        .ENTRIES    (ENTRIES),
        .PW         (PW)
    ) u_mem (
        .clock    (clock),
        .wr_en    (arr_wr & ~bus.i_flush),
        .wr_ptr   (wr_ptr_q),
        .wr_value (bus.i_value),
        .rd_ptr   (rd_ptr_q),
        .rd_value (rd_value)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            value_q  <= '0;
            ready_q  <= 1'b0;
            af_q     <= 1'b0;
        end else if (bus.i_flush) begin
            // Any output transfer this edge has already been taken downstream.
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
            af_q     <= 1'b0;
        end else begin
            if (arr_wr) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (load_arr) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
                valid_q  <= 1'b1;
                value_q  <= rd_value;
            end else if (load_byp) begin
                valid_q  <= 1'b1;
                value_q  <= bus.i_value;
            end else if (out_free) begin
                valid_q  <= 1'b0;
            end
            count_q <= count_next;
            ready_q <= (count_next < CNT_FULL);
            af_q    <= (count_next >= CNT_AF);
        end
    end

    assign bus.o_ready       = ready_q;
    assign bus.o_valid       = valid_q;
    assign bus.o_value       = value_q;
    assign bus.o_count       = count_q;
    assign bus.o_almost_full = af_q;

endmodule

// File: tb/tb_handshake_fifo_v1r1.sv
`timescale 1ns/1ps
// Bench for handshake_fifo_v1r1: vector table, hand sequences, and a queue-model random run.
module tb_handshake_fifo_v1r1;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    handshake_fifo_v1r1_if #(.VALUE_BITS(8), .DEPTH(4)) bus4 ();
    handshake_fifo_v1r1_if #(.VALUE_BITS(8), .DEPTH(5)) bus5 ();

    handshake_fifo_v1r1 #(.VALUE_BITS(8), .DEPTH(4), .AF_LEVEL(3)) dut4 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus4)
    );

    handshake_fifo_v1r1 #(.VALUE_BITS(8), .DEPTH(5)) dut5 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus5)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       r;
        logic       e_rdy;
        logic       e_vld;
        logic [7:0] e_val;
        int         e_cnt;
        logic       e_af;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic v, logic [7:0] d, logic r, logic e_rdy,
                                logic e_vld, logic [7:0] e_val, int e_cnt, logic e_af);
        vec_t t;
        t.v = v; t.d = d; t.r = r; t.e_rdy = e_rdy;
        t.e_vld = e_vld; t.e_val = e_val; t.e_cnt = e_cnt; t.e_af = e_af;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check4(input string tag, input logic e_rdy, input logic e_vld,
                          input logic [7:0] e_val, input int e_cnt, input logic e_af);
        chk({tag, ".ready"}, bus4.o_ready, e_rdy);
        chk({tag, ".valid"}, bus4.o_valid, e_vld);
        if (e_vld) chk({tag, ".value"}, bus4.o_value, e_val);
        chk({tag, ".count"}, bus4.o_count, e_cnt);
        chk({tag, ".af"}, bus4.o_almost_full, e_af);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive4(input logic v, input logic [7:0] d, input logic r, input logic f);
        bus4.i_valid = v; bus4.i_value = d; bus4.i_ready = r; bus4.i_flush = f;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        logic [7:0] q[$];
        logic       exp_rdy;
        logic       v, r, f, in_x, out_x;
        logic [7:0] d;

        drive4(0, 8'h00, 0, 0);
        bus5.i_valid = 0; bus5.i_value = '0; bus5.i_ready = 0; bus5.i_flush = 0;

        // Reset held, then released between edges.
        repeat (3) tick();
        check4("reset", 0, 0, 8'h00, 0, 0);
        chk("reset.value", bus4.o_value, 8'h00);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk("release.ready_before_edge", bus4.o_ready, 0);
        chk("release.valid_before_edge", bus4.o_valid, 0);
        tick();
        check4("release", 1, 0, 8'h00, 0, 0);
        chk("release.ready5", bus5.o_ready, 1);

        // Single item, then stall fill / drain with wrap of the 3-entry array.
        vecs.push_back(mk(1, 8'h5A, 1, 1, 1, 8'h5A, 1, 0));
        vecs.push_back(mk(0, 8'h00, 1, 1, 0, 8'h00, 0, 0));
        vecs.push_back(mk(1, 8'h01, 0, 1, 1, 8'h01, 1, 0));
        vecs.push_back(mk(1, 8'h02, 0, 1, 1, 8'h01, 2, 0));
        vecs.push_back(mk(1, 8'h03, 0, 1, 1, 8'h01, 3, 1));
        vecs.push_back(mk(1, 8'h04, 0, 0, 1, 8'h01, 4, 1));
        vecs.push_back(mk(1, 8'h05, 0, 0, 1, 8'h01, 4, 1));
        vecs.push_back(mk(1, 8'h05, 1, 1, 1, 8'h02, 3, 1));
        vecs.push_back(mk(1, 8'h05, 1, 1, 1, 8'h03, 3, 1));
        vecs.push_back(mk(1, 8'h06, 1, 1, 1, 8'h04, 3, 1));
        vecs.push_back(mk(0, 8'h00, 1, 1, 1, 8'h05, 2, 0));
        vecs.push_back(mk(0, 8'h00, 1, 1, 1, 8'h06, 1, 0));
        vecs.push_back(mk(0, 8'h00, 1, 1, 0, 8'h00, 0, 0));
        for (int i = 0; i < vecs.size(); i++) begin
            drive4(vecs[i].v, vecs[i].d, vecs[i].r, 0);
            tick();
            check4($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_vld,
                   vecs[i].e_val, vecs[i].e_cnt, vecs[i].e_af);
        end

        // Continuous streaming.
        for (int k = 0; k < 256; k++) begin
            drive4(1, 8'(k), 1, 0);
            tick();
            check4($sformatf("stream%0d", k), 1, 1, 8'(k), 1, 0);
        end
        drive4(0, 8'h00, 1, 0);
        tick();
        check4("stream_drain", 1, 0, 8'h00, 0, 0);

        // Flush with three items held and an input offered on the flush edge.
        for (int k = 0; k < 3; k++) begin
            drive4(1, 8'(8'h10 + k), 0, 0);
            tick();
        end
        check4("pre_flush", 1, 1, 8'h10, 3, 1);
        drive4(1, 8'h13, 1, 1);
        #1;
        chk("flush_edge.valid", bus4.o_valid, 1);
        chk("flush_edge.value", bus4.o_value, 8'h10);
        tick();
        drive4(0, 8'h00, 1, 0);
        check4("post_flush", 1, 0, 8'h00, 0, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("post_flush%0d.valid", k), bus4.o_valid, 0);
            chk($sformatf("post_flush%0d.count", k), bus4.o_count, 0);
        end

        // Asynchronous reset in the middle of a cycle with data held.
        drive4(1, 8'h77, 0, 0);
        tick();
        tick();
        check4("pre_reset", 1, 1, 8'h77, 2, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check4("mid_reset", 0, 0, 8'h00, 0, 0);
        chk("mid_reset.value", bus4.o_value, 8'h00);
        drive4(0, 8'h00, 0, 0);
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        check4("after_reset", 1, 0, 8'h00, 0, 0);

        // Random run on DEPTH=5 against a queue model.
        exp_rdy = 1'b1;
        for (int c = 0; c < 200; c++) begin
            v = ($urandom_range(0, 99) < 70);
            r = ($urandom_range(0, 99) < ((c < 100) ? 35 : 70));
            f = ($urandom_range(0, 39) == 0);
            d = 8'($urandom);
            bus5.i_valid = v; bus5.i_value = d; bus5.i_ready = r; bus5.i_flush = f;
            in_x  = v && exp_rdy;
            out_x = (q.size() > 0) && r;
            if (out_x) void'(q.pop_front());
            if (f) q.delete();
            else if (in_x) q.push_back(d);
            exp_rdy = f ? 1'b1 : (q.size() < 5);
            tick();
            chk($sformatf("rnd%0d.count", c), bus5.o_count, q.size());
            chk($sformatf("rnd%0d.valid", c), bus5.o_valid, q.size() > 0);
            if (q.size() > 0) chk($sformatf("rnd%0d.value", c), bus5.o_value, q[0]);
            chk($sformatf("rnd%0d.ready", c), bus5.o_ready, exp_rdy);
            chk($sformatf("rnd%0d.af", c), bus5.o_almost_full, q.size() >= 4);
        end
        bus5.i_valid = 0; bus5.i_flush = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
